// File: rtl/soc_timer_sequencer.sv
// AXI-Lite master that programs the SoC countdown timer, services each timer IRQ
// (status read + clear pulse), counts events and disables the timer on budget end or stop.
module soc_timer_sequencer #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    CNT_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] LOAD_OFF   = 5'h00,
    parameter logic [ADDR_WIDTH-1:0] CTRL_OFF   = 5'h04,
    parameter logic [ADDR_WIDTH-1:0] CLR_OFF    = 5'h08,
    parameter logic [ADDR_WIDTH-1:0] STAT_OFF   = 5'h10
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   cmd_load,
    input  logic                    cmd_reload,
    input  logic [CNT_WIDTH-1:0]    cmd_count,
    input  logic                    stop_req,
    input  logic                    timer_irq,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RVALID,
    output logic                    RREADY,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [CNT_WIDTH-1:0]    event_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WR_LOAD, ST_WR_CTRL, ST_RUN, ST_RD_STAT, ST_CLR_SET, ST_CLR_REL, ST_WR_DIS
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic                    issued_r, reload_r, stop_pend_r, term_r;
    logic [DATA_WIDTH-1:0]   load_r;
    logic [CNT_WIDTH-1:0]    count_r, cnt_next_s;
    logic                    launch_wr_s, launch_rd_s, accept_s, cnt_inc_s;
    logic                    term_set_s, term_clr_s, done_s, err_s;
    logic                    wr_done_s, rd_done_s, wr_err_s, rd_err_s;
    logic [ADDR_WIDTH-1:0]   wr_addr_s;
    logic [DATA_WIDTH-1:0]   wr_data_s;
    logic                    unused_rdata_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign wr_done_s      = BREADY && BVALID;
    assign rd_done_s      = RREADY && RVALID;
    assign wr_err_s       = wr_done_s && (BRESP != 2'b00);
    assign rd_err_s       = rd_done_s && (RRESP != 2'b00);
    assign cnt_next_s     = sat_inc(event_cnt);
    assign unused_rdata_s = ^RDATA[DATA_WIDTH-1:1];

    // Next-state and per-state beat selection; a bus error overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        launch_wr_s = 1'b0;
        launch_rd_s = 1'b0;
        wr_addr_s   = {ADDR_WIDTH{1'b0}};
        wr_data_s   = {DATA_WIDTH{1'b0}};
        accept_s    = 1'b0;
        cnt_inc_s   = 1'b0;
        term_set_s  = 1'b0;
        term_clr_s  = 1'b0;
        done_s      = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_WR_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR_LOAD: begin
                wr_addr_s   = LOAD_OFF;
                wr_data_s   = load_r;
                launch_wr_s = !issued_r;
                state_nxt_s = wr_done_s ? ST_WR_CTRL : ST_WR_LOAD;
            end
            ST_WR_CTRL: begin
                wr_addr_s   = CTRL_OFF;
                wr_data_s   = {{(DATA_WIDTH-2){1'b0}}, reload_r, 1'b1};
                launch_wr_s = !issued_r;
                state_nxt_s = wr_done_s ? ST_RUN : ST_WR_CTRL;
            end
            ST_RUN: begin
                if (stop_pend_r) begin
                    state_nxt_s = ST_WR_DIS;
                end else if (timer_irq) begin
                    state_nxt_s = ST_RD_STAT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RD_STAT: begin
                launch_rd_s = !issued_r;
                if (rd_done_s && RDATA[0]) begin
                    term_clr_s  = 1'b1;
                    state_nxt_s = ST_CLR_SET;
                end else if (rd_done_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_RD_STAT;
                end
            end
            ST_CLR_SET: begin
                wr_addr_s   = CLR_OFF;
                wr_data_s   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
                launch_wr_s = !issued_r;
                state_nxt_s = wr_done_s ? ST_CLR_REL : ST_CLR_SET;
            end
            ST_CLR_REL: begin
                wr_addr_s   = CLR_OFF;
                launch_wr_s = !issued_r;
                if (wr_done_s && term_r) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (wr_done_s) begin
                    cnt_inc_s = 1'b1;
                    if (!reload_r) begin
                        done_s      = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else if ((count_r != {CNT_WIDTH{1'b0}}) && (cnt_next_s == count_r)) begin
                        state_nxt_s = ST_WR_DIS;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_CLR_REL;
                end
            end
            ST_WR_DIS: begin
                wr_addr_s   = CTRL_OFF;
                launch_wr_s = !issued_r;
                term_set_s  = wr_done_s;
                state_nxt_s = wr_done_s ? ST_CLR_SET : ST_WR_DIS;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (wr_err_s || rd_err_s) begin
            state_nxt_s = ST_IDLE;
            err_s       = 1'b1;
            done_s      = 1'b0;
            cnt_inc_s   = 1'b0;
            term_set_s  = 1'b0;
            term_clr_s  = 1'b0;
        end else begin
            err_s = 1'b0;
        end
    end

    // Sequencer state, latched command and event bookkeeping.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r     <= ST_IDLE;
            issued_r    <= 1'b0;
            load_r      <= {DATA_WIDTH{1'b0}};
            reload_r    <= 1'b0;
            count_r     <= {CNT_WIDTH{1'b0}};
            stop_pend_r <= 1'b0;
            term_r      <= 1'b0;
            event_cnt   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (launch_wr_s || launch_rd_s) begin
                issued_r <= 1'b1;
            end else if (wr_done_s || rd_done_s) begin
                issued_r <= 1'b0;
            end
            if (accept_s) begin
                load_r      <= cmd_load;
                reload_r    <= cmd_reload;
                count_r     <= cmd_count;
                stop_pend_r <= 1'b0;
                term_r      <= 1'b0;
                event_cnt   <= {CNT_WIDTH{1'b0}};
            end else begin
                if ((state_r != ST_IDLE) && stop_req) stop_pend_r <= 1'b1;
                if (term_set_s) term_r <= 1'b1;
                else if (term_clr_s) term_r <= 1'b0;
                if (cnt_inc_s) event_cnt <= cnt_next_s;
            end
        end
    end

    // AXI channel registers: each valid/ready drops on its own handshake.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            AWADDR  <= {ADDR_WIDTH{1'b0}};
            AWVALID <= 1'b0;
            WDATA   <= {DATA_WIDTH{1'b0}};
            WSTRB   <= {(DATA_WIDTH/8){1'b0}};
            WVALID  <= 1'b0;
            BREADY  <= 1'b0;
            ARADDR  <= {ADDR_WIDTH{1'b0}};
            ARVALID <= 1'b0;
            RREADY  <= 1'b0;
        end else begin
            if (launch_wr_s) begin
                AWADDR  <= wr_addr_s;
                WDATA   <= wr_data_s;
                WSTRB   <= {(DATA_WIDTH/8){1'b1}};
                AWVALID <= 1'b1;
                WVALID  <= 1'b1;
                BREADY  <= 1'b1;
            end else begin
                if (AWVALID && AWREADY) AWVALID <= 1'b0;
                if (WVALID && WREADY) WVALID <= 1'b0;
                if (wr_done_s) BREADY <= 1'b0;
            end
            if (launch_rd_s) begin
                ARADDR  <= STAT_OFF;
                ARVALID <= 1'b1;
                RREADY  <= 1'b1;
            end else begin
                if (ARVALID && ARREADY) ARVALID <= 1'b0;
                if (rd_done_s) RREADY <= 1'b0;
            end
        end
    end

    // Registered handshake/status outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            cmd_ready <= (state_nxt_s == ST_IDLE);
            busy      <= (state_nxt_s != ST_IDLE);
            done      <= done_s;
            err       <= err_s;
        end
    end

endmodule

// File: tb/tb_soc_timer_sequencer.sv
// Directed + randomized bench for soc_timer_sequencer: a behavioural AXI-Lite timer
// slave logs every beat, and expected beat lists are built from the command rules.
module tb_soc_timer_sequencer;
    localparam int CW   = 3;
    localparam int MAXC = (1 << CW) - 1;
    localparam logic [4:0] LOAD_A = 5'h00, CTRL_A = 5'h04, CLR_A = 5'h08, STAT_A = 5'h10;

    logic ACLK = 1'b0, ARESETN = 1'b0;
    logic cmd_valid = 1'b0, cmd_reload = 1'b0, stop_req = 1'b0, fire = 1'b0, fire_spur = 1'b0;
    logic [31:0] cmd_load = 32'd0;
    logic [CW-1:0] cmd_count = '0;
    logic cmd_ready, busy, done, err, timer_irq;
    logic [CW-1:0] event_cnt;
    logic [4:0] AWADDR, ARADDR;
    logic [31:0] WDATA, RDATA;
    logic [3:0] WSTRB;
    logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0] BRESP, RRESP;

    logic aw_got, w_got, ar_got, int_status, spur;
    logic [4:0] aw_lat;
    logic [31:0] w_lat;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    int aw_dly = 0, w_dly = 0, b_dly = 0;
    logic err_en = 1'b0;
    logic [4:0] err_addr = 5'h00;
    logic [63:0] log_q[$];
    logic [63:0] exp_q[$];
    int checks = 0, errors = 0, viol = 0, done_cnt = 0, err_cnt = 0;
    int base = 0, done0 = 0, err0 = 0;
    logic awv_p, wv_p, arv_p, done_p, err_p;

    assign timer_irq = int_status | spur;

    soc_timer_sequencer #(.CNT_WIDTH(CW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_load(cmd_load), .cmd_reload(cmd_reload), .cmd_count(cmd_count),
        .stop_req(stop_req), .timer_irq(timer_irq),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .WVALID(WVALID), .WREADY(WREADY), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .RDATA(RDATA), .RRESP(RRESP),
        .RVALID(RVALID), .RREADY(RREADY), .busy(busy), .done(done), .err(err), .event_cnt(event_cnt)
    );

    always #5 ACLK = ~ACLK;

    // Timer slave: programmable ready/response delays, IRQ status, beat log.
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            AWREADY <= 1'b0; WREADY <= 1'b0; BVALID <= 1'b0; BRESP <= 2'b00;
            ARREADY <= 1'b0; RVALID <= 1'b0; RDATA <= 32'd0; RRESP <= 2'b00;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
            aw_lat <= 5'd0; w_lat <= 32'd0; int_status <= 1'b0; spur <= 1'b0;
        end else begin
            if (fire) int_status <= 1'b1;
            if (fire_spur) spur <= 1'b1;
            if (AWVALID && !aw_got) begin
                if (AWREADY) begin aw_got <= 1'b1; AWREADY <= 1'b0; aw_lat <= AWADDR; end
                else if (aw_wait >= aw_dly) AWREADY <= 1'b1;
                else aw_wait <= aw_wait + 1;
            end
            if (WVALID && !w_got) begin
                if (WREADY) begin w_got <= 1'b1; WREADY <= 1'b0; w_lat <= WDATA; end
                else if (w_wait >= w_dly) WREADY <= 1'b1;
                else w_wait <= w_wait + 1;
            end
            if (aw_got && w_got && !BVALID) begin
                if (b_wait >= b_dly) begin
                    BVALID <= 1'b1;
                    BRESP  <= (err_en && aw_lat == err_addr) ? 2'b10 : 2'b00;
                end else b_wait <= b_wait + 1;
            end
            if (BVALID && BREADY) begin
                BVALID <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
                aw_wait <= 0; w_wait <= 0; b_wait <= 0;
                log_q.push_back({8'h57, 19'd0, aw_lat, w_lat});
                if (aw_lat == CLR_A && w_lat[0]) int_status <= 1'b0;
            end
            if (ARVALID && !ar_got) begin
                if (ARREADY) begin ar_got <= 1'b1; ARREADY <= 1'b0; spur <= 1'b0; end
                else if (ar_wait >= aw_dly) ARREADY <= 1'b1;
                else ar_wait <= ar_wait + 1;
            end
            if (ar_got && !RVALID) begin
                if (r_wait >= b_dly) begin RVALID <= 1'b1; RDATA <= {31'd0, int_status}; RRESP <= 2'b00; end
                else r_wait <= r_wait + 1;
            end
            if (RVALID && RREADY) begin
                RVALID <= 1'b0; ar_got <= 1'b0; ar_wait <= 0; r_wait <= 0;
                log_q.push_back({8'h52, 19'd0, STAT_A, RDATA});
            end
        end
    end

    // Protocol watcher: valid pairing/drop rules, single outstanding beat, pulse widths.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            awv_p <= 1'b0; wv_p <= 1'b0; arv_p <= 1'b0; done_p <= 1'b0; err_p <= 1'b0;
        end else begin
            if ((AWVALID && !awv_p) != (WVALID && !wv_p)) viol <= viol + 1;
            if (WVALID && WSTRB != 4'hF) viol <= viol + 1;
            if ((AWVALID || WVALID || BREADY) && (ARVALID || RREADY)) viol <= viol + 1;
            if ((awv_p && !AWVALID && !aw_got) || (AWVALID && aw_got)) viol <= viol + 1;
            if ((wv_p && !WVALID && !w_got) || (WVALID && w_got)) viol <= viol + 1;
            if ((arv_p && !ARVALID && !ar_got) || (ARVALID && ar_got)) viol <= viol + 1;
            if ((done && done_p) || (err && err_p) || (done && err)) viol <= viol + 1;
            done_cnt <= done_cnt + (done ? 1 : 0);
            err_cnt  <= err_cnt + (err ? 1 : 0);
            awv_p <= AWVALID; wv_p <= WVALID; arv_p <= ARVALID; done_p <= done; err_p <= err;
        end
    end

    function automatic logic [63:0] wr_ent(input logic [4:0] a, input logic [31:0] d);
        return {8'h57, 19'd0, a, d};
    endfunction

    function automatic logic [63:0] rd_ent(input logic [31:0] d);
        return {8'h52, 19'd0, STAT_A, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valids"}, {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 64'd0);
        chk({tag, "_cmd_ready"}, cmd_ready, 64'd1);
        chk({tag, "_busy_done_err"}, {busy, done, err}, 64'd0);
        chk({tag, "_event_cnt"}, event_cnt, 64'd0);
        chk({tag, "_addr_data"}, {AWADDR, ARADDR, WDATA}, 64'd0);
    endtask

    task automatic send(input logic [31:0] ld, input logic rl, input logic [CW-1:0] ct);
        int k = 0;
        while (!cmd_ready && k < 1000) begin @(negedge ACLK); k++; end
        chk("cmd_ready_wait", cmd_ready, 64'd1);
        cmd_load = ld; cmd_reload = rl; cmd_count = ct; cmd_valid = 1'b1;
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    task automatic start(input logic [31:0] ld, input logic rl, input logic [CW-1:0] ct);
        exp_q.delete();
        base = log_q.size(); done0 = done_cnt; err0 = err_cnt;
        exp_q.push_back(wr_ent(LOAD_A, ld));
        exp_q.push_back(wr_ent(CTRL_A, {30'd0, rl, 1'b1}));
        send(ld, rl, ct);
    endtask

    task automatic wait_log();
        int k = 0;
        while (log_q.size() < base + exp_q.size() && k < 3000) begin @(negedge ACLK); k++; end
        chk("wait_log", log_q.size() >= base + exp_q.size(), 64'd1);
    endtask

    task automatic pulse_fire();
        fire = 1'b1; @(negedge ACLK); fire = 1'b0;
    endtask

    task automatic service();
        pulse_fire();
        exp_q.push_back(rd_ent(32'd1));
        exp_q.push_back(wr_ent(CLR_A, 32'd1));
        exp_q.push_back(wr_ent(CLR_A, 32'd0));
        wait_log();
    endtask

    task automatic expect_disable();
        exp_q.push_back(wr_ent(CTRL_A, 32'd0));
        exp_q.push_back(wr_ent(CLR_A, 32'd1));
        exp_q.push_back(wr_ent(CLR_A, 32'd0));
    endtask

    task automatic finish_chk(input string tag, input int exp_evt, input int exp_done, input int exp_err);
        int k = 0;
        int n;
        while (busy && k < 3000) begin @(negedge ACLK); k++; end
        chk({tag, "_idle"}, busy, 64'd0);
        @(negedge ACLK); @(negedge ACLK);
        chk({tag, "_log_len"}, log_q.size() - base, exp_q.size());
        n = (log_q.size() - base < exp_q.size()) ? log_q.size() - base : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_beat"}, log_q[base + i], exp_q[i]);
        chk({tag, "_event_cnt"}, event_cnt, exp_evt);
        chk({tag, "_done_pulses"}, done_cnt - done0, exp_done);
        chk({tag, "_err_pulses"}, err_cnt - err0, exp_err);
        chk({tag, "_cmd_ready"}, cmd_ready, 64'd1);
    endtask

    initial begin
        logic rl;
        int ct, nserv, k;
        repeat (3) @(negedge ACLK);
        chk_reset_outputs("reset");
        ARESETN = 1'b1;
        @(negedge ACLK);

        // one-shot
        start(32'd5, 1'b0, 3'd0);
        service();
        finish_chk("oneshot", 1, 1, 0);

        // auto-reload with budget 4, plus a command offered while busy
        aw_dly = 1; w_dly = 2; b_dly = 1;
        start(32'd3, 1'b1, 3'd4);
        service();
        cmd_load = 32'd99; cmd_valid = 1'b1; @(negedge ACLK); cmd_valid = 1'b0;
        repeat (3) service();
        expect_disable();
        finish_chk("reload4", 4, 1, 0);

        // unlimited; stop during CLR_SET, new irq raised during CLR_REL (stop must win)
        aw_dly = 0; w_dly = 0; b_dly = 2;
        start($urandom, 1'b1, 3'd0);
        service();
        pulse_fire();
        exp_q.push_back(rd_ent(32'd1));
        wait_log();
        stop_req = 1'b1; @(negedge ACLK); stop_req = 1'b0;
        exp_q.push_back(wr_ent(CLR_A, 32'd1));
        wait_log();
        pulse_fire();
        exp_q.push_back(wr_ent(CLR_A, 32'd0));
        expect_disable();
        finish_chk("stop", 2, 1, 0);

        // SLVERR on CTRL write
        err_en = 1'b1; err_addr = CTRL_A;
        start($urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, MAXC)));
        finish_chk("slverr", 0, 0, 1);
        err_en = 1'b0;

        // spurious irq, then a budget of 2
        start($urandom, 1'b1, 3'd2);
        fire_spur = 1'b1; @(negedge ACLK); fire_spur = 1'b0;
        exp_q.push_back(rd_ent(32'd0));
        wait_log();
        repeat (4) @(negedge ACLK);
        chk("spur_event_cnt", event_cnt, 64'd0);
        chk("spur_still_busy", busy, 64'd1);
        repeat (2) service();
        expect_disable();
        finish_chk("spur", 2, 1, 0);

        // saturation in unlimited mode, then a stop while idle in RUN
        start($urandom, 1'b1, 3'd0);
        repeat (MAXC + 2) service();
        chk("sat_event_cnt", event_cnt, (MAXC + 2 > MAXC) ? MAXC : MAXC + 2);
        stop_req = 1'b1; @(negedge ACLK); stop_req = 1'b0;
        expect_disable();
        finish_chk("sat", MAXC, 1, 0);

        // randomized commands
        repeat (6) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            rl = 1'($urandom_range(0, 1));
            ct = $urandom_range(1, 5);
            nserv = rl ? ct : 1;
            start($urandom, rl, 3'(ct));
            repeat (nserv) service();
            if (rl) expect_disable();
            finish_chk("random", nserv, 1, 0);
        end

        // skewed ready timing, reset asserted mid-beat
        aw_dly = 0; w_dly = 3; b_dly = 5;
        send($urandom, 1'b0, 3'd0);
        k = 0;
        while (!(aw_got && !w_got) && k < 50) begin @(negedge ACLK); k++; end
        chk("skew_aw_dropped", {AWVALID, WVALID, BREADY}, 64'b011);
        repeat (5) @(negedge ACLK);
        chk("skew_in_b_wait", {AWVALID, WVALID, BREADY, busy}, 64'b0011);
        ARESETN = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk_reset_outputs("postreset");
        aw_dly = 0; w_dly = 0; b_dly = 0;
        start($urandom, 1'b0, 3'd1);
        service();
        finish_chk("recover", 1, 1, 0);

        chk("protocol_violations", viol, 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
